// File: rtl/sn_tok_pkg.sv
// Shared token types for the snooper/forwarder buffer-token queue.
// Token 0 is NULL (no buffer); valid tokens are 1..N_BUFS.
package sn_tok_pkg;

  localparam int unsigned TOKQ_N_BUFS  = 4;
  localparam int unsigned TOKQ_TOKEN_W = $clog2(TOKQ_N_BUFS + 1);

  typedef logic [TOKQ_TOKEN_W-1:0] tok_t;

  localparam tok_t NULL_TOK = '0;

  function automatic logic tok_valid(input int unsigned t, input int unsigned n_bufs);
    return (t != 32'(NULL_TOK)) && (t <= n_bufs);
  endfunction

endpackage

// File: rtl/sn_tok_presence.sv
// Presence bitmap of buffer tokens: bit k tracks token k+1, all present out of reset.
// Two set ports, one clear port (set wins), two combinational query ports.
module sn_tok_presence #(
  parameter int unsigned N_BUFS  = 4,
  parameter int unsigned TOKEN_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_set_a_vld,
  input  logic [TOKEN_W-1:0] i_set_a_tok,
  input  logic               i_set_b_vld,
  input  logic [TOKEN_W-1:0] i_set_b_tok,
  input  logic               i_clr_vld,
  input  logic [TOKEN_W-1:0] i_clr_tok,
  input  logic [TOKEN_W-1:0] i_qry_a_tok,
  output logic               o_qry_a_hit,
  input  logic [TOKEN_W-1:0] i_qry_b_tok,
  output logic               o_qry_b_hit
);

  logic [N_BUFS-1:0] r_bits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bits <= '1;
    end else begin
      for (int k = 0; k < int'(N_BUFS); k++) begin
        if ((i_set_a_vld && (i_set_a_tok == TOKEN_W'(k + 1))) ||
            (i_set_b_vld && (i_set_b_tok == TOKEN_W'(k + 1)))) begin
          r_bits[k] <= 1'b1;
        end else if (i_clr_vld && (i_clr_tok == TOKEN_W'(k + 1))) begin
          r_bits[k] <= 1'b0;
        end
      end
    end
  end

  // Out-of-range tokens (NULL or > N_BUFS) never hit.
  always_comb begin
    o_qry_a_hit = 1'b0;
    o_qry_b_hit = 1'b0;
    for (int k = 0; k < int'(N_BUFS); k++) begin
      if (i_qry_a_tok == TOKEN_W'(k + 1)) o_qry_a_hit = r_bits[k];
      if (i_qry_b_tok == TOKEN_W'(k + 1)) o_qry_b_hit = r_bits[k];
    end
  end

endmodule

// File: rtl/sn_token_queue.sv
// Buffer-token FIFO of N_BUFS entries; enqueues show at head one cycle later, drops on no space set overflow_err.
// Optional duplicate-token guard built when `TOKQ_DUP_CHECK_EN is defined (presence bitmap, sticky dup_err).
module sn_token_queue
  import sn_tok_pkg::*;
#(
  parameter int unsigned N_BUFS  = TOKQ_N_BUFS,
  parameter int unsigned TOKEN_W = $clog2(N_BUFS + 1),
  parameter int unsigned CNT_W   = $clog2(N_BUFS + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [TOKEN_W-1:0] token_from_cpu,
  input  logic               en_from_cpu,
  input  logic [TOKEN_W-1:0] token_from_fwd,
  input  logic               en_from_fwd,
  input  logic               deq,
  output logic [TOKEN_W-1:0] head,
  output logic               head_valid,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty,
  output logic               overflow_err,
  output logic               dup_err
);

  localparam int unsigned PTR_W = $clog2(N_BUFS);

  logic [TOKEN_W-1:0] r_mem [N_BUFS];
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_ovf;

  logic               w_deq_acc;
  logic               w_cpu_nz, w_fwd_nz;
  logic               w_cpu_dup, w_fwd_dup;
  logic               w_cpu_ok, w_fwd_ok;
  logic               w_cpu_acc, w_fwd_acc;
  logic               w_ovf_set;
  logic [CNT_W-1:0]   w_space;
  logic [PTR_W-1:0]   w_wr_ptr1;
  logic [PTR_W-1:0]   w_fwd_ptr;
  logic [1:0]         w_n_acc;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(N_BUFS - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_deq_acc = deq && (r_count != '0);
  assign w_cpu_nz  = en_from_cpu && (32'(token_from_cpu) != 32'(NULL_TOK));
  assign w_fwd_nz  = en_from_fwd && (32'(token_from_fwd) != 32'(NULL_TOK));

`ifdef TOKQ_DUP_CHECK_EN
  logic w_cpu_hit, w_fwd_hit;
  logic r_dup;

  sn_tok_presence #(
    .N_BUFS  (N_BUFS),
    .TOKEN_W (TOKEN_W)
  ) u_presence (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_set_a_vld (w_cpu_acc),
    .i_set_a_tok (token_from_cpu),
    .i_set_b_vld (w_fwd_acc),
    .i_set_b_tok (token_from_fwd),
    .i_clr_vld   (w_deq_acc),
    .i_clr_tok   (r_mem[r_rd_ptr]),
    .i_qry_a_tok (token_from_cpu),
    .o_qry_a_hit (w_cpu_hit),
    .i_qry_b_tok (token_from_fwd),
    .o_qry_b_hit (w_fwd_hit)
  );

  // The head being dequeued this cycle still counts as present.
  assign w_cpu_dup = w_cpu_nz && (!tok_valid(32'(token_from_cpu), N_BUFS) || w_cpu_hit);
  assign w_fwd_dup = w_fwd_nz && (!tok_valid(32'(token_from_fwd), N_BUFS) || w_fwd_hit ||
                                  (w_cpu_nz && (token_from_fwd == token_from_cpu)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dup <= 1'b0;
    end else if (w_cpu_dup || w_fwd_dup) begin
      r_dup <= 1'b1;
    end
  end

  assign dup_err = r_dup;
`else
  assign w_cpu_dup = 1'b0;
  assign w_fwd_dup = 1'b0;
  assign dup_err   = 1'b0;
`endif

  assign w_space   = CNT_W'(N_BUFS) - r_count + CNT_W'(w_deq_acc);
  assign w_cpu_ok  = w_cpu_nz && !w_cpu_dup;
  assign w_fwd_ok  = w_fwd_nz && !w_fwd_dup;
  assign w_cpu_acc = w_cpu_ok && (w_space != '0);
  assign w_fwd_acc = w_fwd_ok && (w_space > CNT_W'(w_cpu_acc));
  assign w_ovf_set = (w_cpu_ok && !w_cpu_acc) || (w_fwd_ok && !w_fwd_acc);
  assign w_n_acc   = {1'b0, w_cpu_acc} + {1'b0, w_fwd_acc};
  assign w_wr_ptr1 = ptr_inc(r_wr_ptr);
  assign w_fwd_ptr = w_cpu_acc ? w_wr_ptr1 : r_wr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_BUFS); i++) begin
        r_mem[i] <= TOKEN_W'(i + 1);
      end
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= CNT_W'(N_BUFS);
      r_ovf    <= 1'b0;
    end else begin
      if (w_cpu_acc) r_mem[r_wr_ptr] <= token_from_cpu;
      if (w_fwd_acc) r_mem[w_fwd_ptr] <= token_from_fwd;
      case (w_n_acc)
        2'd1:    r_wr_ptr <= w_wr_ptr1;
        2'd2:    r_wr_ptr <= ptr_inc(w_wr_ptr1);
        default: r_wr_ptr <= r_wr_ptr;
      endcase
      if (w_deq_acc) r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + CNT_W'(w_n_acc) - CNT_W'(w_deq_acc);
      if (w_ovf_set) r_ovf <= 1'b1;
    end
  end

  assign head_valid   = (r_count != '0);
  assign head         = head_valid ? r_mem[r_rd_ptr] : TOKEN_W'(0);
  assign count        = r_count;
  assign full         = (r_count == CNT_W'(N_BUFS));
  assign empty        = (r_count == '0);
  assign overflow_err = r_ovf;

endmodule

// File: tb/tb_sn_token_queue.sv
// Directed bench for sn_token_queue (N_BUFS=4): vector table plus hand sequences for overflow, duplicates and reset.
module tb_sn_token_queue;
  import sn_tok_pkg::*;

  logic       clk;
  logic       rst_n;
  tok_t       token_from_cpu, token_from_fwd;
  logic       en_from_cpu, en_from_fwd, deq;
  tok_t       head;
  logic       head_valid, full, empty, overflow_err, dup_err;
  logic [2:0] count;

  int n_chk;
  int n_pass;

  sn_token_queue #(.N_BUFS(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .token_from_cpu (token_from_cpu),
    .en_from_cpu    (en_from_cpu),
    .token_from_fwd (token_from_fwd),
    .en_from_fwd    (en_from_fwd),
    .deq            (deq),
    .head           (head),
    .head_valid     (head_valid),
    .count          (count),
    .full           (full),
    .empty          (empty),
    .overflow_err   (overflow_err),
    .dup_err        (dup_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic d;
    logic ec;
    int   tc;
    logic ef;
    int   tf;
    int   head;
    int   cnt;
  } vec_t;

  vec_t tv[26];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic chk_state(input string tag, input int e_head, input int e_cnt,
                           input int e_ovf, input int e_dup);
    chk({tag, " head"},  int'(head), e_head);
    chk({tag, " hvld"},  int'(head_valid), int'(e_cnt != 0));
    chk({tag, " count"}, int'(count), e_cnt);
    chk({tag, " full"},  int'(full), int'(e_cnt == 4));
    chk({tag, " empty"}, int'(empty), int'(e_cnt == 0));
    chk({tag, " ovf"},   int'(overflow_err), e_ovf);
    chk({tag, " dup"},   int'(dup_err), e_dup);
  endtask

  // Called at a negedge; drives one cycle, leaves outputs settled after the posedge, returns at next negedge.
  task automatic cyc(input logic d, input logic ec, input int tc, input logic ef, input int tf);
    deq = d;
    en_from_cpu = ec;
    token_from_cpu = tok_t'(tc);
    en_from_fwd = ef;
    token_from_fwd = tok_t'(tf);
    @(posedge clk);
    #1;
    deq = 1'b0;
    en_from_cpu = 1'b0;
    en_from_fwd = 1'b0;
    token_from_cpu = '0;
    token_from_fwd = '0;
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    deq = 1'b0;
    en_from_cpu = 1'b0;
    en_from_fwd = 1'b0;
    token_from_cpu = '0;
    token_from_fwd = '0;

    //            d  ec tc ef tf  head cnt
    tv[0]  = '{1'b1, 1'b0, 0, 1'b0, 0, 2, 3};
    tv[1]  = '{1'b1, 1'b0, 0, 1'b0, 0, 3, 2};
    tv[2]  = '{1'b1, 1'b0, 0, 1'b0, 0, 4, 1};
    tv[3]  = '{1'b1, 1'b0, 0, 1'b0, 0, 0, 0};
    tv[4]  = '{1'b1, 1'b0, 0, 1'b0, 0, 0, 0};
    tv[5]  = '{1'b0, 1'b1, 3, 1'b1, 1, 3, 2};
    tv[6]  = '{1'b1, 1'b0, 0, 1'b0, 0, 1, 1};
    tv[7]  = '{1'b1, 1'b0, 0, 1'b0, 0, 0, 0};
    tv[8]  = '{1'b1, 1'b1, 2, 1'b0, 0, 2, 1};
    tv[9]  = '{1'b0, 1'b1, 0, 1'b0, 0, 2, 1};
    tv[10] = '{1'b0, 1'b1, 4, 1'b1, 1, 2, 3};
    tv[11] = '{1'b0, 1'b1, 3, 1'b0, 0, 2, 4};
    tv[12] = '{1'b1, 1'b0, 0, 1'b0, 0, 4, 3};
    tv[13] = '{1'b0, 1'b1, 2, 1'b0, 0, 4, 4};
    tv[14] = '{1'b1, 1'b0, 0, 1'b0, 0, 1, 3};
    tv[15] = '{1'b0, 1'b0, 0, 1'b1, 4, 1, 4};
    tv[16] = '{1'b1, 1'b0, 0, 1'b0, 0, 3, 3};
    tv[17] = '{1'b0, 1'b1, 1, 1'b0, 0, 3, 4};
    tv[18] = '{1'b1, 1'b0, 0, 1'b0, 0, 2, 3};
    tv[19] = '{1'b0, 1'b0, 0, 1'b1, 3, 2, 4};
    tv[20] = '{1'b1, 1'b0, 0, 1'b0, 0, 4, 3};
    tv[21] = '{1'b0, 1'b1, 2, 1'b0, 0, 4, 4};
    tv[22] = '{1'b1, 1'b0, 0, 1'b0, 0, 1, 3};
    tv[23] = '{1'b1, 1'b0, 0, 1'b0, 0, 3, 2};
    tv[24] = '{1'b1, 1'b0, 0, 1'b0, 0, 2, 1};
    tv[25] = '{1'b1, 1'b0, 0, 1'b0, 0, 0, 0};

    @(negedge clk);
    @(negedge clk);
    #1;
    chk_state("reset", 1, 4, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 26; i++) begin
      cyc(tv[i].d, tv[i].ec, tv[i].tc, tv[i].ef, tv[i].tf);
      chk_state($sformatf("v%0d", i), tv[i].head, tv[i].cnt, 0, 0);
    end

    // Full queue: enqueue with and without a same-cycle dequeue.
    reset_pulse();
    cyc(1'b1, 1'b1, 2, 1'b0, 0);
`ifdef TOKQ_DUP_CHECK_EN
    chk_state("full_deq_enq", 2, 3, 0, 1);
`else
    chk_state("full_deq_enq", 2, 4, 0, 0);
`endif
    cyc(1'b0, 1'b1, 2, 1'b0, 0);
`ifdef TOKQ_DUP_CHECK_EN
    chk_state("full_enq", 2, 3, 0, 1);
`else
    chk_state("full_enq", 2, 4, 1, 0);
`endif
    cyc(1'b0, 1'b0, 0, 1'b0, 0);
`ifdef TOKQ_DUP_CHECK_EN
    chk_state("sticky", 2, 3, 0, 1);
    cyc(1'b1, 1'b0, 0, 1'b0, 0);
    cyc(1'b1, 1'b0, 0, 1'b0, 0);
    chk_state("drain_to_1", 4, 1, 0, 1);
`else
    chk_state("sticky", 2, 4, 1, 0);
    cyc(1'b1, 1'b0, 0, 1'b0, 0);
    cyc(1'b1, 1'b0, 0, 1'b0, 0);
    cyc(1'b1, 1'b0, 0, 1'b0, 0);
    chk_state("drain_to_1", 2, 1, 1, 0);
`endif

    // Asynchronous reset mid-cycle, sampled before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk_state("async_rst", 1, 4, 0, 0);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Full + deq, both ports enqueue: only one slot, CPU wins.
    cyc(1'b1, 1'b1, 1, 1'b1, 3);
`ifdef TOKQ_DUP_CHECK_EN
    chk_state("port_order", 2, 3, 0, 1);
`else
    chk_state("port_order", 2, 4, 1, 0);
    cyc(1'b1, 1'b0, 0, 1'b0, 0);
    cyc(1'b1, 1'b0, 0, 1'b0, 0);
    cyc(1'b1, 1'b0, 0, 1'b0, 0);
    chk_state("port_order_tail", 1, 1, 1, 0);
`endif

    // Re-enqueue of a token still queued, then of a freed one.
    reset_pulse();
    cyc(1'b1, 1'b0, 0, 1'b0, 0);
    chk_state("dup_pre", 2, 3, 0, 0);
    cyc(1'b0, 1'b1, 2, 1'b0, 0);
`ifdef TOKQ_DUP_CHECK_EN
    chk_state("dup_tok2", 2, 3, 0, 1);
    cyc(1'b0, 1'b1, 1, 1'b0, 0);
    chk_state("dup_tok1", 2, 4, 0, 1);
    cyc(1'b1, 1'b0, 0, 1'b0, 0);
    chk_state("dup_order1", 3, 3, 0, 1);
    cyc(1'b1, 1'b0, 0, 1'b0, 0);
    cyc(1'b1, 1'b0, 0, 1'b0, 0);
    chk_state("dup_order3", 1, 1, 0, 1);
`else
    chk_state("dup_tok2", 2, 4, 0, 0);
    cyc(1'b0, 1'b1, 1, 1'b0, 0);
    chk_state("dup_tok1", 2, 4, 1, 0);
    cyc(1'b1, 1'b0, 0, 1'b0, 0);
    chk_state("dup_order1", 3, 3, 1, 0);
    cyc(1'b1, 1'b0, 0, 1'b0, 0);
    cyc(1'b1, 1'b0, 0, 1'b0, 0);
    chk_state("dup_order3", 2, 1, 1, 0);
`endif

    // Both ports return the same token in one cycle.
    reset_pulse();
    cyc(1'b1, 1'b0, 0, 1'b0, 0);
    cyc(1'b1, 1'b0, 0, 1'b0, 0);
    chk_state("same_pre", 3, 2, 0, 0);
    cyc(1'b0, 1'b1, 1, 1'b1, 1);
`ifdef TOKQ_DUP_CHECK_EN
    chk_state("same_tok", 3, 3, 0, 1);
`else
    chk_state("same_tok", 3, 4, 0, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
